// File: rtl/data_mem_responder_pkg.sv
// data_mem_pkg: shared types and widths for the data-port memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W  : data word width
//   ADDR_W  : byte address width
//   CNT_W   : wait-counter width (holds latencies 1..15)
package data_mem_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between the core's
// memory stage (master) and the data memory responder (slave).
//   Req*  : request channel, valid/ready, with write flag, byte address, store data
//   Resp* : response channel, valid/ready, with load data and error flag
interface data_mem_responder_if;
  import data_mem_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddress;
  logic [WORD_W-1:0] ReqWriteData;
  logic              RespValid;
  logic              RespReady;
  logic [WORD_W-1:0] RespData;
  logic              RespError;

  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqWriteData, RespReady,
    input  ReqReady, RespValid, RespData, RespError
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, RespReady,
    output ReqReady, RespValid, RespData, RespError
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// data_mem_array: word-organised storage for the responder.
//   clk   : clock
//   we    : write enable, write happens on the rising edge
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : asynchronous read of the word at idx
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-outstanding-request memory responder for the CPU data
// port. A request is accepted in IDLE, waits LATENCY cycles, the access is done
// on the WAIT->RESP edge, and the response is held until RespReady.
//   CLK   : clock
//   Reset : synchronous, active-high; storage contents survive it
//   bus   : request/response handshake bundle (slave side)
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic                  CLK,
  input logic                  Reset,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              access;
  logic              req_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign accept = (state_reg == IDLE) && bus.ReqValid;
  assign access = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));

  // Out of range means any address bit above the word index is set; the
  // index never wraps onto a real word.
  assign req_err = (addr_reg[1:0] != 2'b00) || (addr_reg[ADDR_W-1:IDX_W+2] != '0);
  assign mem_we  = access && wr_reg && !req_err;

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .idx   (addr_reg[IDX_W+1:2]),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.ReqValid)  state_next = WAIT;
      WAIT:    if (access)        state_next = RESP;
      RESP:    if (bus.RespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, wait counter and response registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_reg   <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg   <= CNT_W'(LATENCY);
        wr_reg    <= bus.ReqWrite;
        addr_reg  <= bus.ReqAddress;
        wdata_reg <= bus.ReqWriteData;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end

      if (access) begin
        rdata_reg <= (!req_err && !wr_reg) ? mem_rdata : '0;
        err_reg   <= req_err;
      end else if ((state_reg == RESP) && bus.RespReady) begin
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end
    end
  end

  // Outputs; everything reads as zero while Reset is held, even mid-response
  always_comb begin
    bus.ReqReady  = 1'b0;
    bus.RespValid = 1'b0;
    bus.RespData  = '0;
    bus.RespError = 1'b0;
    if (!Reset) begin
      bus.ReqReady  = (state_reg == IDLE);
      bus.RespValid = (state_reg == RESP);
      bus.RespData  = rdata_reg;
      bus.RespError = err_reg;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench. dut0 uses LATENCY=2, dut1 uses
// LATENCY=1; both DEPTH_WORDS=256. A word-level memory model predicts results.
module tb_data_mem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req_valid, req_write, resp_ready;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  wire  [1:0]  req_ready, resp_valid, resp_error;
  wire  [31:0] resp_data [2];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.ReqValid = req_valid[0];
  assign bus0.ReqWrite = req_write[0];
  assign bus0.ReqAddress = req_addr[0];
  assign bus0.ReqWriteData = req_wdata[0];
  assign bus0.RespReady = resp_ready[0];
  assign bus1.ReqValid = req_valid[1];
  assign bus1.ReqWrite = req_write[1];
  assign bus1.ReqAddress = req_addr[1];
  assign bus1.ReqWriteData = req_wdata[1];
  assign bus1.RespReady = resp_ready[1];
  assign req_ready  = {bus1.ReqReady, bus0.ReqReady};
  assign resp_valid = {bus1.RespValid, bus0.RespValid};
  assign resp_error = {bus1.RespError, bus0.RespError};
  assign resp_data[0] = bus0.RespData;
  assign resp_data[1] = bus1.RespData;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
    .CLK(clk), .Reset(rst[0]), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .CLK(clk), .Reset(rst[1]), .bus(bus1));

  int checks = 0;
  int failures = 0;

  // Reference model: word index -> value, only for words known to be written.
  logic [31:0] model [int unsigned];
  int lat_of [2] = '{2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // One full transaction. Entered and left at posedge+1 of a cycle.
  task automatic txn(input int sel, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input bit chk_data,
                     input logic [31:0] exp_data, input bit exp_err);
    int w, n;
    logic [31:0] held;
    w = 0;
    while (!req_ready[sel] && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_req", 32'(req_ready[sel]), 32'd1);
    resp_ready[sel] = (hold == 0);
    req_valid[sel] = 1'b1;
    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wd;
    @(posedge clk); #1;
    // Scramble the fields: only the accepting edge may matter.
    req_valid[sel] = 1'b0;
    req_write[sel] = 1'($urandom);
    req_addr[sel]  = $urandom;
    req_wdata[sel] = $urandom;
    n = 1;
    forever begin
      check("ready_low_while_busy", 32'(req_ready[sel]), 32'd0);
      if (resp_valid[sel] || n >= 60) break;
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(lat_of[sel] + 1));
    held = resp_data[sel];
    if (chk_data) check("resp_data", resp_data[sel], exp_data);
    check("resp_error", 32'(resp_error[sel]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid[sel] = 1'b1;      // must be ignored while in RESP
      req_write[sel] = 1'b1;
      req_addr[sel]  = 32'h0000_0040;
      @(posedge clk); #1;
      req_valid[sel] = 1'b0;
      check("bp_valid_held", 32'(resp_valid[sel]), 32'd1);
      check("bp_data_held", resp_data[sel], held);
      check("bp_ready_low", 32'(req_ready[sel]), 32'd0);
    end
    resp_ready[sel] = 1'b1;
    req_valid[sel] = 1'b1;        // not accepted on the handshake edge
    req_write[sel] = 1'b1;
    req_addr[sel]  = 32'h0000_0044;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    check("post_valid_clr", 32'(resp_valid[sel]), 32'd0);
    check("post_data_clr", resp_data[sel], 32'd0);
    check("post_err_clr", 32'(resp_error[sel]), 32'd0);
    check("post_idle", 32'(req_ready[sel]), 32'd1);
    $display("txn dut%0d %s addr=%h wd=%h data=%h lat=%0d hold=%0d", sel,
             wr ? "ST" : "LD", addr, wd, held, n, hold);
  endtask

  // Transaction whose expectation comes from the model, which it then updates.
  task automatic model_txn(input int sel, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
    bit e;
    bit known;
    logic [31:0] exp;
    e = addr_err(addr);
    known = wr || e || model.exists(addr >> 2);
    exp = (wr || e) ? 32'd0 : (known ? model[addr >> 2] : 32'd0);
    txn(sel, wr, addr, wd, hold, known, exp, e);
    if (wr && !e) model[addr >> 2] = wd;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1111_2222, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'h9999_9999, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0402, 32'h5555_5555, 32'h0, 1'b1};

    rst = 2'b11; req_valid = 2'b00; req_write = 2'b00; resp_ready = 2'b11;
    for (int s = 0; s < 2; s++) begin
      req_addr[s] = '0; req_wdata[s] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        check("rst_ready", 32'(req_ready[s]), 32'd0);
        check("rst_valid", 32'(resp_valid[s]), 32'd0);
        check("rst_data", resp_data[s], 32'd0);
        check("rst_err", 32'(resp_error[s]), 32'd0);
      end
    end
    rst = 2'b00; #1;
    check("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // Directed table on dut0 (LATENCY=2)
    for (int i = 0; i < 11; i++) begin
      txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, 0, 1'b1, vecs[i].exp_data, vecs[i].exp_err);
      if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr >> 2] = vecs[i].wd;
    end

    // Backpressure: response held for 5 cycles
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 5, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT drops the store
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h0000_0020; req_wdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b1; #1;
    check("rstw_ready", 32'(req_ready[0]), 32'd0);
    check("rstw_valid", 32'(resp_valid[0]), 32'd0);
    check("rstw_data", resp_data[0], 32'd0);
    check("rstw_err", 32'(resp_error[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; #1;
    check("rstw_idle", 32'(req_ready[0]), 32'd1);
    $display("txn dut0 RESET-IN-WAIT store 0x20 aborted");
    model_txn(0, 1'b0, 32'h0000_0020, 32'h0, 0);

    // Reset during RESP discards the response
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0000_0010;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 0; c < 20 && !resp_valid[0]; c++) begin
      @(posedge clk); #1;
    end
    check("rstr_reached_resp", 32'(resp_valid[0]), 32'd1);
    rst[0] = 1'b1; #1;
    check("rstr_valid", 32'(resp_valid[0]), 32'd0);
    check("rstr_data", resp_data[0], 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0; #1;
    check("rstr_valid_after", 32'(resp_valid[0]), 32'd0);
    check("rstr_data_after", resp_data[0], 32'd0);
    check("rstr_idle", 32'(req_ready[0]), 32'd1);
    resp_ready[0] = 1'b1;
    $display("txn dut0 RESET-IN-RESP load 0x10 discarded");

    // Randomized traffic on dut0
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h0000_0400 + (32'($urandom_range(0, 1023)) << 2);
      else             a = 32'($urandom_range(250, 255)) << 2;
      model_txn(0, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    // LATENCY=1 back-to-back on dut1
    for (int i = 0; i < 4; i++)
      model_txn(1, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i * 17), 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1'b0, 32'(i * 4), 32'h0, 0, 1'b1, 32'hC0DE_0000 + 32'(i * 17), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data port: accepts one load/store request at a time over a valid/ready handshake, services it against word-organised storage after a fixed programmable latency, and returns a response over a second valid/ready handshake. It replaces the zero-wait RAM on the pipelined core's data path. The core's memory stage becomes the initiator, and can stall on ReqReady/RespValid.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; power of two, ≥ 4.
- LATENCY, 2, wait cycles between acceptance and response; legal range 1–15.

Ports:
- CLK  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  reset is synchronous and active-high.
- ReqValid  in  1  initiator presents a request.
- ReqReady  out  1  responder can accept; high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddress  in  32  byte address.
- ReqWriteData  in  32  store data.
- RespValid  out  1  response available.
- RespReady  in  1  initiator takes the response.
- RespData  out  32  load data; 0 for stores and errors.
- RespError  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - On ReqValid&&ReqReady: latch ReqWrite, ReqAddress, ReqWriteData; load the wait counter with LATENCY; go to WAIT.
- WAIT:
  - ReqReady=0.
  - Decrement the counter each cycle.
  - On the edge where the counter equals 1, perform the access and go to RESP.
- Access:
  - Word index = addr[31:2].
  - Error if addr[1:0]≠0 or word index ≥ DEPTH_WORDS.
  - Error: no storage update; RespData=0; RespError=1.
  - Store: write latched data to the word; RespData=0.
  - Load: capture the word into the RespData register.
- RESP:
  - RespValid=1. RespData and RespError are held stable until the handshake.
  - On RespReady: go to IDLE; RespValid, RespData and RespError clear to 0 on the same edge.
- One outstanding request. No request is accepted while WAIT or RESP is active, even if RespReady is high in the same cycle.
- Storage is not cleared by Reset. Load data from never-written words is don't-care for checking.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - ReqReady=1 from the cycle after Reset deasserts. It is 0 while Reset is high.
  - RespValid=0, RespData=0, RespError=0.
- Latency: a request accepted at the edge ending cycle T produces RespValid=1 in cycle T+LATENCY+1.
  - LATENCY=1 gives RespValid in T+2.
- Minimum request spacing is LATENCY+2 cycles when RespReady is held high.
- Store commit happens at the WAIT→RESP edge. A load issued after a store's response sees the new data.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the request. A store whose commit edge has not occurred is dropped.
  - Reset in RESP discards the pending response.
- If ReqValid falls before acceptance, nothing is latched. ReqValid/fields are sampled only on the accepting edge; later changes are ignored.
- If RespReady is low, RESP persists indefinitely with all outputs stable.

## Structure
- Shared package `data_mem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - width constants WORD_W=32 and ADDR_W=32;
  - counter width 4.
- Sub-module `data_mem_array`, containing:
  - DEPTH_WORDS×32 storage;
  - synchronous write with enable and index;
  - asynchronous read by index.
- The responder top holds the FSM, counter, request latches, range/alignment check and response registers.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with LATENCY=2 and RespReady=1.
  - Required: ReqReady low 3 cycles; RespValid in T+3 with RespData=0 and RespError=0.
  - Then load 0x10 → RespData=0xDEADBEEF.
- Misaligned load 0x13 → RespError=1, RespData=0.
  - Store to 0x400 (DEPTH_WORDS=256) → RespError=1.
  - A later load of 0x0 returns its unchanged prior value.
- Backpressure: load 0x10 with RespReady held low for 5 cycles.
  - Required: RespValid/RespData=0xDEADBEEF stable throughout; ReqValid pulses ignored.
  - Release → IDLE next cycle.
- Store 0x12345678 to 0x20, assert Reset during WAIT, then load 0x20.
  - Required: the old value is returned; all outputs are 0 during Reset.
- LATENCY=1 back-to-back: 4 stores then 4 loads to 0x0,0x4,0x8,0xC with RespReady=1.
  - Required: each response appears exactly 2 cycles after acceptance; readback matches.
